// File: rtl/mant_negate_serial_if.sv
// +-----------------------------------------------------------------------+
// | mant_negate_serial_if : operand/result handshake bundle               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface mant_negate_serial_if #(
   parameter int W = 23
) ();
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] b;
   logic [1:0]   mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         xout;
   logic         cout;

   modport master (
      output in_valid, b, mode, out_ready,
      input  in_ready, out_valid, out, xout, cout
   );

   modport slave (
      input  in_valid, b, mode, out_ready,
      output in_ready, out_valid, out, xout, cout
   );
endinterface

`default_nettype wire

// File: rtl/mant_negate_serial.sv
// +-----------------------------------------------------------------------+
// | mant_negate_serial : CHUNK-bit-per-clock pass/negate/ones-complement   |
// | of {HIDDEN, B}; Rev 1.0                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module mant_negate_serial #(
   parameter int W      = 23,
   parameter int CHUNK  = 4,
   parameter int HIDDEN = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   mant_negate_serial_if.slave bus
);
   localparam int             NSLICE = (W + 1) / CHUNK;
   localparam int             CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0]  LAST   = CW'(NSLICE - 1);

   generate
      if (((W + 1) % CHUNK) != 0) begin : g_chunk_check
         $error("mant_negate_serial: CHUNK must divide W+1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [W:0]      opnd;
   logic [W:0]      work;
   logic [W:0]      work_nxt;
   logic [W:0]      res;
   logic [1:0]      mode_q;
   logic            carry;
   logic            cout_q;
   logic [CW-1:0]   cnt;
   logic            in_ready;
   logic            out_valid;
   logic            accept;
   logic            last;
   logic            invert;
   logic [CHUNK:0]  sum;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reserved mode 11 falls through to pass: no inversion, zero carry-in.
   assign invert = (mode_q == 2'b01) || (mode_q == 2'b10);
   assign sum    = {1'b0, opnd[CHUNK-1:0] ^ {CHUNK{invert}}} + {{CHUNK{1'b0}}, carry};

   // Operand shifts down and results shift in from the top, so slice k is
   // always at the bottom of opnd on the k-th RUN edge.
   generate
      if (NSLICE == 1) begin : g_single
         assign work_nxt = sum[CHUNK-1:0];
      end else begin : g_multi
         assign work_nxt = {sum[CHUNK-1:0], work[W:CHUNK]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opnd   <= '0;
         work   <= '0;
         res    <= '0;
         mode_q <= 2'b00;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         opnd   <= {1'(HIDDEN), bus.b};
         mode_q <= bus.mode;
         carry  <= (bus.mode == 2'b01);
         cnt    <= '0;
      end else if (state == RUN) begin
         opnd  <= opnd >> CHUNK;
         work  <= work_nxt;
         carry <= sum[CHUNK];
         if (last) begin
            res    <= work_nxt;
            cout_q <= sum[CHUNK];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out       = res[W-1:0];
   assign bus.xout      = res[W];
   assign bus.cout      = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_mant_negate_serial.sv
// Bench for mant_negate_serial: default, HIDDEN=0 and CHUNK=1 instances
// checked against an arithmetic reference model.
`default_nettype none

module tb_mant_negate_serial;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mant_negate_serial_if #(.W(23)) if0 ();
   mant_negate_serial_if #(.W(23)) if1 ();
   mant_negate_serial_if #(.W(23)) if2 ();

   mant_negate_serial #(.W(23), .CHUNK(4), .HIDDEN(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   mant_negate_serial #(.W(23), .CHUNK(4), .HIDDEN(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   mant_negate_serial #(.W(23), .CHUNK(1), .HIDDEN(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   // Reference result packed as {cout, xout, out[22:0]}.
   function automatic logic [24:0] model(input logic [1:0] m, input logic [22:0] bv, input bit hid);
      int unsigned e;
      int unsigned r;
      bit          c;
      e = {8'h0, hid, bv};
      c = 1'b0;
      case (m)
         2'b01:   begin r = (32'h0100_0000 - e) % 32'h0100_0000; c = (e == 0); end
         2'b10:   r = 32'h00FF_FFFF - e;
         default: r = e;
      endcase
      return {c, r[23:0]};
   endfunction

   // {in_ready, out_valid, cout, xout, out}
   function automatic logic [26:0] get(input int s);
      case (s)
         0:       return {if0.in_ready, if0.out_valid, if0.cout, if0.xout, if0.out};
         1:       return {if1.in_ready, if1.out_valid, if1.cout, if1.xout, if1.out};
         default: return {if2.in_ready, if2.out_valid, if2.cout, if2.xout, if2.out};
      endcase
   endfunction

   task automatic put(input int s, input logic v, input logic [1:0] m, input logic [22:0] bv);
      case (s)
         0:       begin if0.in_valid = v; if0.mode = m; if0.b = bv; end
         1:       begin if1.in_valid = v; if1.mode = m; if1.b = bv; end
         default: begin if2.in_valid = v; if2.mode = m; if2.b = bv; end
      endcase
   endtask

   task automatic set_ordy(input int s, input logic v);
      case (s)
         0:       if0.out_ready = v;
         1:       if1.out_ready = v;
         default: if2.out_ready = v;
      endcase
   endtask

   task automatic drive(input int s, input logic [1:0] m, input logic [22:0] bv, input bit noisy,
                        output logic [24:0] res, output int lat);
      int          guard = 0;
      logic [26:0] g;
      g = get(s);
      while (!g[26] && guard < 50) begin
         @(posedge clk); #1; guard++; g = get(s);
      end
      checks++;
      if (!g[26]) begin
         failures++;
         $display("FAIL accept_wait dut=%0d in_ready=%b required=1", s, g[26]);
      end
      put(s, 1'b1, m, bv);
      @(posedge clk); #1;
      if (!noisy) put(s, 1'b0, m, bv);
      lat = 0;
      g = get(s);
      while (!g[25] && lat < 100) begin
         if (noisy) put(s, 1'b1, 2'($urandom), 23'($urandom));
         @(posedge clk); #1; lat++; g = get(s);
      end
      put(s, 1'b0, m, bv);
      res = g[24:0];
   endtask

   task automatic consume(input int s);
      set_ordy(s, 1'b1);
      @(posedge clk); #1;
      set_ordy(s, 1'b0);
   endtask

   task automatic test_reset;
      for (int s = 0; s < 3; s++) begin put(s, 1'b1, 2'b01, 23'h1); set_ordy(s, 1'b1); end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (get(s) !== {2'b10, 25'h0}) begin
            failures++;
            $display("FAIL reset_state dut=%0d got=%h required=%h", s, get(s), {2'b10, 25'h0});
         end
         put(s, 1'b0, 2'b00, 23'h0); set_ordy(s, 1'b0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (get(0) !== {2'b10, 25'h0}) begin
         failures++;
         $display("FAIL reset_release got=%h required=%h", get(0), {2'b10, 25'h0});
      end
   endtask

   task automatic test_directed;
      logic [1:0]  dm [5] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
      logic [22:0] db [5] = '{23'h000000, 23'h000001, 23'h123456, 23'h7FFFFF, 23'h55AA55};
      logic [24:0] de [5] = '{{2'b01, 23'h000000}, {2'b00, 23'h7FFFFF}, {2'b01, 23'h123456},
                              {2'b00, 23'h000000}, {2'b01, 23'h55AA55}};
      logic [24:0] res;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         drive(0, dm[i], db[i], 1'b0, res, lat);
         checks++;
         if (res !== de[i]) begin
            failures++;
            $display("FAIL directed_%0d got=%h required=%h", i, res, de[i]);
         end
         checks++;
         if (lat !== 6) begin
            failures++;
            $display("FAIL directed_lat_%0d got=%0d required=6", i, lat);
         end
         consume(0);
      end
   endtask

   task automatic test_variants;
      logic [24:0] res;
      int          lat;
      logic [1:0]  m;
      logic [22:0] bv;
      drive(1, 2'b01, 23'h0, 1'b0, res, lat);
      checks++;
      if (res !== {2'b10, 23'h0} || lat !== 6) begin
         failures++;
         $display("FAIL hidden0_neg_zero got=%h lat=%0d required=%h lat=6", res, lat, {2'b10, 23'h0});
      end
      consume(1);
      drive(2, 2'b01, 23'h1, 1'b0, res, lat);
      checks++;
      if (res !== {2'b00, 23'h7FFFFF} || lat !== 24) begin
         failures++;
         $display("FAIL chunk1_neg_one got=%h lat=%0d required=%h lat=24", res, lat, {2'b00, 23'h7FFFFF});
      end
      consume(2);
      for (int i = 0; i < 8; i++) begin
         int s;
         s  = 1 + (i % 2);
         m  = 2'($urandom);
         bv = 23'($urandom);
         drive(s, m, bv, i[2], res, lat);
         checks++;
         if (res !== model(m, bv, s != 1) || lat !== ((s == 2) ? 24 : 6)) begin
            failures++;
            $display("FAIL variant_rand dut=%0d mode=%b b=%h got=%h lat=%0d required=%h",
                     s, m, bv, res, lat, model(m, bv, s != 1));
         end
         consume(s);
      end
   endtask

   task automatic test_random;
      logic [24:0] res;
      int          lat;
      logic [1:0]  m;
      logic [22:0] bv;
      for (int i = 0; i < 40; i++) begin
         m  = 2'($urandom);
         bv = (i % 8 == 3) ? 23'h0 : 23'($urandom);
         drive(0, m, bv, i[0], res, lat);
         checks++;
         if (res !== model(m, bv, 1'b1) || lat !== 6) begin
            failures++;
            $display("FAIL random_%0d mode=%b b=%h got=%h lat=%0d required=%h lat=6",
                     i, m, bv, res, lat, model(m, bv, 1'b1));
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         consume(0);
      end
   endtask

   task automatic test_hold;
      logic [24:0] res, exp0, exp1;
      logic [1:0]  nm;
      logic [22:0] nb;
      int          lat;
      logic [26:0] g;
      drive(0, 2'b01, 23'h2468AC, 1'b0, res, lat);
      exp0 = model(2'b01, 23'h2468AC, 1'b1);
      for (int i = 0; i < 10; i++) begin
         put(0, 1'b1, 2'($urandom), 23'($urandom));
         @(posedge clk); #1;
         checks++;
         if (get(0) !== {2'b01, exp0}) begin
            failures++;
            $display("FAIL hold_cycle_%0d got=%h required=%h", i, get(0), {2'b01, exp0});
         end
      end
      nm = 2'b10; nb = 23'h13579B;
      exp1 = model(nm, nb, 1'b1);
      put(0, 1'b1, nm, nb);
      consume(0);
      checks++;
      if (get(0) !== {2'b10, exp0}) begin
         failures++;
         $display("FAIL hold_after_done got=%h required=%h", get(0), {2'b10, exp0});
      end
      @(posedge clk); #1;
      put(0, 1'b0, nm, nb);
      checks++;
      if (get(0) !== {2'b00, exp0}) begin
         failures++;
         $display("FAIL hold_accept got=%h required=%h", get(0), {2'b00, exp0});
      end
      lat = 0; g = get(0);
      while (!g[25] && lat < 100) begin @(posedge clk); #1; lat++; g = get(0); end
      checks++;
      if (g[24:0] !== exp1 || lat !== 6) begin
         failures++;
         $display("FAIL hold_next_op got=%h lat=%0d required=%h lat=6", g[24:0], lat, exp1);
      end
      consume(0);
   endtask

   task automatic test_reset_mid;
      logic [24:0] res;
      int          lat;
      bit          seen = 1'b0;
      put(0, 1'b1, 2'b01, 23'h0F0F0F);
      @(posedge clk); #1;
      put(0, 1'b0, 2'b01, 23'h0F0F0F);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (get(0) !== {2'b10, 25'h0}) begin
         failures++;
         $display("FAIL reset_mid_state got=%h required=%h", get(0), {2'b10, 25'h0});
      end
      set_ordy(0, 1'b1);
      repeat (10) begin
         @(posedge clk); #1;
         if (get(0) >> 25 !== 27'b10) seen = 1'b1;
      end
      set_ordy(0, 1'b0);
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_ghost got=%b required=0", seen);
      end
      drive(0, 2'b01, 23'h000001, 1'b0, res, lat);
      checks++;
      if (res !== model(2'b01, 23'h000001, 1'b1) || lat !== 6) begin
         failures++;
         $display("FAIL reset_mid_next got=%h lat=%0d required=%h lat=6", res, lat, model(2'b01, 23'h1, 1'b1));
      end
      consume(0);
   endtask

   task automatic test_back_to_back;
      logic [24:0] expq [$];
      logic [24:0] exp_v;
      logic [26:0] g;
      logic [1:0]  nm;
      logic [22:0] nb;
      int          last_acc = -1;
      int          n_done = 0;
      set_ordy(0, 1'b1);
      nm = 2'($urandom); nb = 23'($urandom);
      put(0, 1'b1, nm, nb);
      for (int cyc = 0; cyc < 40; cyc++) begin
         g = get(0);
         if (g[25]) begin
            exp_v = (expq.size() > 0) ? expq.pop_front() : 25'h0;
            n_done++;
            checks++;
            if (g[24:0] !== exp_v) begin
               failures++;
               $display("FAIL b2b_result got=%h required=%h", g[24:0], exp_v);
            end
         end
         if (g[26]) begin
            expq.push_back(model(nm, nb, 1'b1));
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc !== 8) begin
                  failures++;
                  $display("FAIL b2b_interval got=%0d required=8", cyc - last_acc);
               end
            end
            last_acc = cyc;
         end
         @(posedge clk); #1;
         if (g[26]) begin
            nm = 2'($urandom); nb = 23'($urandom);
            put(0, 1'b1, nm, nb);
         end
      end
      put(0, 1'b0, nm, nb);
      repeat (10) begin @(posedge clk); #1; end
      set_ordy(0, 1'b0);
      checks++;
      if (n_done < 4) begin
         failures++;
         $display("FAIL b2b_count got=%0d required>=4", n_done);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_variants;
      test_random;
      test_hold;
      test_reset_mid;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
